// File: rtl/branch_pkg.sv
// Shared types and width helpers for the branch prediction unit.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package branch_pkg;

    // 2-bit saturating direction counter; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;

    // Fields are sized for the widest supported word (64 bits); the unit
    // only uses the low tag/target bits and the unused upper bits are tied
    // to zero on every write.
    localparam int BTB_FIELD_W = 64;

    typedef struct packed {
        logic                   valid;
        logic [BTB_FIELD_W-1:0] tag;
        logic [BTB_FIELD_W-1:0] target;
    } btb_entry_t;

    // Number of index bits for a power-of-two table
    function automatic int idx_bits(input int entries);
        return $clog2(entries);
    endfunction

    // BTB tag width: everything above the index and the 2 byte-offset bits
    function automatic int tag_bits(input int word_size, input int btb_entries);
        return word_size - $clog2(btb_entries) - 2;
    endfunction

endpackage

// File: rtl/branch_pred_unit_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
// Latency: combinational.
// Backpressure: none.
module sat_counter2
    import branch_pkg::*;
(
    input  ctr_e cur,
    input  logic taken,
    output ctr_e nxt
);

    // Step toward the observed outcome, holding at SNT/ST
    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = ctr_e'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = ctr_e'(cur - 2'd1);
        end
    end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch predictor: PHT of 2-bit counters + tagged BTB, resolve-driven training, flush on mispredict.
// Latency: prediction same cycle as fetch_pc; flush/npc_corr one cycle after resolve; table writes visible next cycle.
// Backpressure: none; accepts one resolve per cycle. Optional gshare indexing via BRANCH_GSHARE_EN.
module branch_pred_unit
    import branch_pkg::*;
#(
    parameter int WordSize   = 32,
    parameter int PhtEntries = 256,
    parameter int BtbEntries = 32,
    parameter int CntWidth   = 16,
    parameter int GhrBits    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WordSize-1:0] fetch_pc,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_target,
    input  logic                resolve_valid,
    input  logic [WordSize-1:0] resolve_pc,
    input  logic                resolve_taken,
    input  logic [WordSize-1:0] resolve_target,
    input  logic                resolve_pred_taken,
    input  logic [WordSize-1:0] resolve_pred_target,
    output logic                flush,
    output logic [WordSize-1:0] npc_corr,
    output logic [CntWidth-1:0] br_count,
    output logic [CntWidth-1:0] mispred_count
`ifdef BRANCH_GSHARE_EN
    ,
    output logic [GhrBits-1:0]  pred_ghr,
    input  logic [GhrBits-1:0]  resolve_ghr
`endif
);

    localparam int PhtIdxW = idx_bits(PhtEntries);
    localparam int BtbIdxW = idx_bits(BtbEntries);
    localparam int TagW    = tag_bits(WordSize, BtbEntries);

    ctr_e       pht_q [PhtEntries];
    ctr_e       pht_d [PhtEntries];
    btb_entry_t btb_q [BtbEntries];
    btb_entry_t btb_d [BtbEntries];

    logic                flush_q, flush_d;
    logic [WordSize-1:0] npc_corr_q, npc_corr_d;
    logic [CntWidth-1:0] br_count_q, br_count_d;
    logic [CntWidth-1:0] mispred_count_q, mispred_count_d;

    logic [PhtIdxW-1:0] fetch_pht_idx, upd_pht_idx;
    logic [BtbIdxW-1:0] fetch_btb_idx, upd_btb_idx;
    logic [TagW-1:0]    fetch_tag, upd_tag;
    logic               fetch_hit;
    ctr_e               fetch_ctr;
    ctr_e               upd_cur, upd_nxt;
    logic               mispredict;

`ifdef BRANCH_GSHARE_EN
    logic [GhrBits-1:0] ghr_q, ghr_d;

    // Global history: shift in each resolved outcome at the LSB
    always_comb begin
        ghr_d = ghr_q;
        if (resolve_valid) ghr_d = (ghr_q << 1) | GhrBits'(resolve_taken);
    end

    assign pred_ghr = ghr_q;
`endif

    // Table indices and tags; training uses the history carried with the branch
    always_comb begin
`ifdef BRANCH_GSHARE_EN
        fetch_pht_idx = fetch_pc[PhtIdxW+1:2] ^ PhtIdxW'(ghr_q);
        upd_pht_idx   = resolve_pc[PhtIdxW+1:2] ^ PhtIdxW'(resolve_ghr);
`else
        fetch_pht_idx = fetch_pc[PhtIdxW+1:2];
        upd_pht_idx   = resolve_pc[PhtIdxW+1:2];
`endif
        fetch_btb_idx = fetch_pc[BtbIdxW+1:2];
        upd_btb_idx   = resolve_pc[BtbIdxW+1:2];
        fetch_tag     = fetch_pc[WordSize-1:BtbIdxW+2];
        upd_tag       = resolve_pc[WordSize-1:BtbIdxW+2];
        upd_cur       = pht_q[upd_pht_idx];
    end

    sat_counter2 u_upd_ctr (
        .cur   (upd_cur),
        .taken (resolve_taken),
        .nxt   (upd_nxt)
    );

    // Lookup from registered state only, so a same-cycle update is not bypassed
    always_comb begin
        fetch_ctr   = pht_q[fetch_pht_idx];
        fetch_hit   = btb_q[fetch_btb_idx].valid &&
                      (btb_q[fetch_btb_idx].tag[TagW-1:0] == fetch_tag);
        pred_taken  = fetch_hit && (fetch_ctr inside {WT, ST});
        pred_target = pred_taken ? btb_q[fetch_btb_idx].target[WordSize-1:0]
                                 : fetch_pc + WordSize'(4);
    end

    // Train PHT on every resolve; BTB allocates on taken only, never evicts on not-taken
    always_comb begin
        pht_d = pht_q;
        btb_d = btb_q;
        if (resolve_valid) begin
            pht_d[upd_pht_idx] = upd_nxt;
            if (resolve_taken) begin
                btb_d[upd_btb_idx].valid  = 1'b1;
                btb_d[upd_btb_idx].tag    = BTB_FIELD_W'(upd_tag);
                btb_d[upd_btb_idx].target = BTB_FIELD_W'(resolve_target);
            end
        end
    end

    // Mispredict detection, corrected PC and saturating performance counters
    always_comb begin
        mispredict = resolve_valid &&
                     ((resolve_taken != resolve_pred_taken) ||
                      (resolve_taken && (resolve_target != resolve_pred_target)));
        flush_d    = mispredict;
        npc_corr_d = npc_corr_q;
        if (mispredict) begin
            npc_corr_d = resolve_taken ? resolve_target : resolve_pc + WordSize'(4);
        end
        br_count_d = br_count_q;
        if (resolve_valid && (br_count_q != '1)) br_count_d = br_count_q + 1'b1;
        mispred_count_d = mispred_count_q;
        if (mispredict && (mispred_count_q != '1)) mispred_count_d = mispred_count_q + 1'b1;
    end

    // State registers; reset takes priority over a same-cycle resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PhtEntries; i++) pht_q[i] <= CTR_RESET;
            for (int i = 0; i < BtbEntries; i++) btb_q[i] <= '0;
            flush_q         <= 1'b0;
            npc_corr_q      <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
`ifdef BRANCH_GSHARE_EN
            ghr_q           <= '0;
`endif
        end else begin
            pht_q           <= pht_d;
            btb_q           <= btb_d;
            flush_q         <= flush_d;
            npc_corr_q      <= npc_corr_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
`ifdef BRANCH_GSHARE_EN
            ghr_q           <= ghr_d;
`endif
        end
    end

    assign flush         = flush_q;
    assign npc_corr      = npc_corr_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule
